// File: rtl/vga_line_fetch.sv
// Line-doubling pixel source for the 640x480 timing generator: fetches 320-pixel
// source lines into two ping-pong buffers and replays each word for two pixel clocks.
module vga_line_fetch #(
  parameter int BPP    = 4,
  parameter int HRES   = 320,
  parameter int NLINES = 240,
  parameter int AW     = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              newline,
  input  logic              advance,
  input  logic [7:0]        line,
  output logic [3*BPP-1:0]  pixel,
  input  logic [AW-1:0]     base_addr,
  output logic              mem_req,
  output logic [AW-1:0]     mem_addr,
  input  logic              mem_ack,
  input  logic [3*BPP-1:0]  mem_rdata,
  output logic              underrun,
  output logic [1:0]        fetch_state
);

  localparam int PW = 3 * BPP;
  localparam int IW = $clog2(HRES);

  // Memory handshake: mem_req rises with a stable mem_addr and both hold until a
  // cycle where mem_ack is high; that cycle completes the transfer and carries
  // mem_rdata. A request is never withdrawn before its ack.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ABORT = 2'd2
  } fetch_state_t;

  fetch_state_t  state;
  logic [PW-1:0] buf_mem [2][HRES];
  logic [1:0]    buf_valid;
  logic [7:0]    buf_tag [2];
  logic          disp_sel;
  logic          disp_on;

  logic [7:0]    fetch_tag;
  logic          fetch_buf;
  logic [IW-1:0] fetch_idx;
  logic [7:0]    pend_tag;
  logic [AW-1:0] pend_addr;

  logic [IW-1:0] rd_idx, rd_idx_nxt;
  logic          rd_half, rd_half_nxt;
  logic          rd_done, rd_done_nxt;
  logic [PW-1:0] rd_word;

  logic          line_blank, hit0, hit1, line_hit, new_disp;
  logic [7:0]    tgt_line;
  logic          tgt_cached, tgt_pending, fetch_req;
  logic [AW-1:0] tgt_addr;

  assign fetch_state = state;

  // Decode of the line number presented with newline.
  always_comb begin
    line_blank  = (32'(line) >= NLINES);
    hit0        = buf_valid[0] && (buf_tag[0] == line);
    hit1        = buf_valid[1] && (buf_tag[1] == line);
    line_hit    = !line_blank && (hit0 || hit1);
    new_disp    = line_hit ? !hit0 : disp_sel;
    tgt_line    = (32'(line) + 1 < NLINES) ? line + 8'd1 : 8'd0;
    tgt_cached  = (buf_valid[0] && (buf_tag[0] == tgt_line)) ||
                  (buf_valid[1] && (buf_tag[1] == tgt_line));
    tgt_pending = ((state == REQ) && (fetch_tag == tgt_line)) ||
                  ((state == ABORT) && (pend_tag == tgt_line));
    fetch_req   = newline && !tgt_cached && !tgt_pending;
    tgt_addr    = base_addr + AW'(tgt_line) * AW'(HRES);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      fetch_tag  <= '0;
      fetch_buf  <= 1'b0;
      fetch_idx  <= '0;
      pend_tag   <= '0;
      pend_addr  <= '0;
      buf_valid  <= '0;
      buf_tag[0] <= '0;
      buf_tag[1] <= '0;
      disp_sel   <= 1'b0;
      disp_on    <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      underrun <= newline && !line_blank && !line_hit;
      if (newline) begin
        disp_sel <= new_disp;
        disp_on  <= line_hit;
      end
      // The fetch target is always the buffer that is not on display.
      if (fetch_req) buf_valid[!new_disp] <= 1'b0;

      case (state)
        IDLE: begin
          if (fetch_req) begin
            state     <= REQ;
            mem_req   <= 1'b1;
            mem_addr  <= tgt_addr;
            fetch_tag <= tgt_line;
            fetch_buf <= !new_disp;
            fetch_idx <= '0;
          end
        end
        REQ: begin
          if (fetch_req && mem_ack) begin
            // The in-flight word just completed, so restart without an abort cycle.
            mem_addr  <= tgt_addr;
            fetch_tag <= tgt_line;
            fetch_buf <= !new_disp;
            fetch_idx <= '0;
          end else if (fetch_req) begin
            state     <= ABORT;
            pend_tag  <= tgt_line;
            pend_addr <= tgt_addr;
          end else if (mem_ack) begin
            mem_addr <= mem_addr + 1'b1;
            if (fetch_idx == IW'(HRES - 1)) begin
              state                <= IDLE;
              mem_req              <= 1'b0;
              buf_valid[fetch_buf] <= 1'b1;
              buf_tag[fetch_buf]   <= fetch_tag;
            end else begin
              fetch_idx <= fetch_idx + 1'b1;
            end
          end
        end
        ABORT: begin
          if (mem_ack) begin
            state     <= REQ;
            fetch_idx <= '0;
            fetch_buf <= !new_disp;
            fetch_tag <= fetch_req ? tgt_line : pend_tag;
            mem_addr  <= fetch_req ? tgt_addr : pend_addr;
          end else if (fetch_req) begin
            pend_tag  <= tgt_line;
            pend_addr <= tgt_addr;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  // Aborted words land in the target buffer too; its valid bit is already clear.
  always_ff @(posedge clk) begin
    if ((state == REQ) && mem_ack) buf_mem[fetch_buf][fetch_idx] <= mem_rdata;
  end

  always_comb begin
    rd_idx_nxt  = rd_idx;
    rd_half_nxt = rd_half;
    rd_done_nxt = rd_done;
    if (newline) begin
      rd_idx_nxt  = '0;
      rd_half_nxt = 1'b0;
      rd_done_nxt = 1'b0;
    end else if (advance && !rd_done) begin
      rd_half_nxt = !rd_half;
      if (rd_half) begin
        if (rd_idx == IW'(HRES - 1)) rd_done_nxt = 1'b1;
        else rd_idx_nxt = rd_idx + 1'b1;
      end
    end
  end

  // rd_word is read one cycle ahead so the word is settled before advance uses it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx  <= '0;
      rd_half <= 1'b0;
      rd_done <= 1'b0;
      rd_word <= '0;
    end else begin
      rd_idx  <= rd_idx_nxt;
      rd_half <= rd_half_nxt;
      rd_done <= rd_done_nxt;
      rd_word <= buf_mem[disp_sel][rd_idx_nxt];
    end
  end

  assign pixel = (advance && disp_on && !rd_done) ? rd_word : '0;

endmodule

// File: tb/tb_vga_line_fetch.sv
// Scoreboard bench for vga_line_fetch: drivers push expected pixels, addresses and
// underrun flags into queues; one monitor pops and compares as the DUT responds.
module tb_vga_line_fetch;

  localparam int BPP    = 4;
  localparam int HRES   = 320;
  localparam int NLINES = 240;
  localparam int AW     = 17;
  localparam int PW     = 3 * BPP;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          newline = 1'b0;
  logic          advance = 1'b0;
  logic [7:0]    line = 8'd0;
  logic [PW-1:0] pixel;
  logic [AW-1:0] base_addr = '0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [PW-1:0] mem_rdata;
  logic          underrun;
  logic [1:0]    fetch_state;

  logic          ack_gate = 1'b0;
  int            ack_mode = 2;
  int            ack_cnt = 0;
  int            ack_limit = 0;
  int            cyc = 0;
  logic          nl_prev = 1'b0;

  logic [PW-1:0] pix_q[$];
  logic [AW-1:0] exp_q[$];
  logic          und_q[$];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vga_line_fetch #(.BPP(BPP), .HRES(HRES), .NLINES(NLINES), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .newline(newline), .advance(advance), .line(line),
    .pixel(pixel), .base_addr(base_addr), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .underrun(underrun),
    .fetch_state(fetch_state)
  );

  // Memory model: each word holds the low 12 bits of its own address.
  assign mem_ack   = mem_req && ack_gate;
  assign mem_rdata = mem_addr[PW-1:0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] exp_pix(input int l, input int k);
    logic [AW-1:0] a;
    a = base_addr + AW'(l * HRES + k / 2);
    return a[PW-1:0];
  endfunction

  task automatic expect_fetch(input int l, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base_addr + AW'(l * HRES + i));
  endtask

  task automatic pulse_newline(input int l);
    @(posedge clk); #1;
    newline = 1'b1;
    line    = 8'(l);
    @(posedge clk); #1;
    newline = 1'b0;
  endtask

  task automatic drive_line(input int l, input bit exp_und, input bit show, input int nadv);
    und_q.push_back(exp_und);
    for (int k = 0; k < nadv; k++)
      pix_q.push_back((show && k < 2 * HRES) ? exp_pix(l, k) : '0);
    pulse_newline(l);
    repeat (100) @(posedge clk);
    #1 advance = 1'b1;
    repeat (nadv) @(posedge clk);
    #1 advance = 1'b0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    check({name, "_acks_left"}, exp_q.size(), 0);
    repeat (4) @(posedge clk); #1;
    check({name, "_idle"}, fetch_state, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n   = 1'b0;
    newline = 1'b0;
    advance = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Responder: ack policy 0=every cycle, 1=every 3rd cycle, 2=never, 3=up to ack_limit.
  initial forever begin
    @(posedge clk); #1;
    cyc++;
    case (ack_mode)
      0:       ack_gate = 1'b1;
      1:       ack_gate = (cyc % 3 == 0);
      2:       ack_gate = 1'b0;
      default: ack_gate = (ack_cnt < ack_limit);
    endcase
  end

  // Monitor / scoreboard.
  initial forever begin
    @(negedge clk);
    if (mem_req && mem_ack) begin
      ack_cnt++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL mem_addr: unexpected ack at %0h, none required", mem_addr);
      end else begin
        check("mem_addr", mem_addr, exp_q.pop_front());
      end
    end
    if (advance) begin
      if (pix_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL pixel: advance with no expectation, got %0h", pixel);
      end else begin
        check("pixel", pixel, pix_q.pop_front());
      end
    end
    if (nl_prev) check("underrun_nl", underrun, (und_q.size() > 0) ? und_q.pop_front() : 1'b0);
    else check("underrun_idle", underrun, 0);
    nl_prev = newline;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_pixel", pixel, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_underrun", underrun, 0);
    check("rst_state", fetch_state, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset mid-fetch: no acks, so the first fetch is still requesting.
    pulse_newline(5);
    check("mid_mem_req", mem_req, 1);
    check("mid_underrun", underrun, 1);
    check("mid_mem_addr", mem_addr, 1920);
    #2 rst_n = 1'b0;
    #1;
    check("async_mem_req", mem_req, 0);
    check("async_pixel", pixel, 0);
    check("async_underrun", underrun, 0);
    check("async_mem_addr", mem_addr, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    ack_mode = 0;
    expect_fetch(6, HRES);
    drive_line(5, 1'b1, 1'b0, 640);
    wait_drain("fetch6");

    // Vblank then steady doubled lines; line 3 gets extra advance pulses.
    expect_fetch(0, HRES);
    drive_line(250, 1'b0, 1'b0, 640);
    expect_fetch(1, HRES);
    drive_line(0, 1'b0, 1'b1, 640);
    drive_line(0, 1'b0, 1'b1, 640);
    expect_fetch(2, HRES);
    drive_line(1, 1'b0, 1'b1, 640);
    drive_line(1, 1'b0, 1'b1, 640);
    expect_fetch(3, HRES);
    drive_line(2, 1'b0, 1'b1, 640);
    drive_line(2, 1'b0, 1'b1, 640);
    expect_fetch(4, HRES);
    drive_line(3, 1'b0, 1'b1, 646);
    drive_line(3, 1'b0, 1'b1, 640);
    wait_drain("steady");

    // Slow memory: first line pair misses, the next pair is shown.
    do_reset();
    ack_mode = 1;
    expect_fetch(1, HRES);
    drive_line(0, 1'b1, 1'b0, 640);
    drive_line(0, 1'b1, 1'b0, 640);
    expect_fetch(2, HRES);
    drive_line(1, 1'b0, 1'b1, 640);
    drive_line(1, 1'b0, 1'b1, 640);
    wait_drain("slow");

    // Abort: line 10 fetch interrupted after 50 acks by newline(20).
    do_reset();
    ack_mode  = 3;
    ack_limit = ack_cnt + 50;
    expect_fetch(10, 51);
    expect_fetch(21, HRES);
    und_q.push_back(1'b1);
    pulse_newline(9);
    t = 0;
    while (ack_cnt < ack_limit && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    check("abort_50_acks", ack_cnt, ack_limit);
    check("abort_hold_addr", mem_addr, 10 * HRES + 50);
    check("abort_hold_req", mem_req, 1);
    fork
      drive_line(20, 1'b1, 1'b0, 640);
      begin
        repeat (5) @(posedge clk);
        #1;
        check("abort_state", fetch_state, 2);
        check("abort_addr_held", mem_addr, 10 * HRES + 50);
        ack_mode = 0;
      end
    join
    expect_fetch(11, HRES);
    drive_line(10, 1'b1, 1'b0, 640);
    expect_fetch(12, HRES);
    drive_line(11, 1'b0, 1'b1, 640);
    wait_drain("abort");

    // Address wrap at the top of the 17-bit space, plus target wrap after line 239.
    do_reset();
    base_addr = 17'h1FF00;
    expect_fetch(0, HRES);
    drive_line(239, 1'b1, 1'b0, 640);
    expect_fetch(1, HRES);
    drive_line(0, 1'b0, 1'b1, 640);
    wait_drain("wrap");

    check("pix_q_empty", pix_q.size(), 0);
    check("und_q_empty", und_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
